// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundles the pipeline-side hazard inputs and the controller's stall/flush/forward outputs.
// Latency: none; pure signal grouping.
// Backpressure: carries the stall/flush controls the controller applies to the pipeline.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    // Instruction in ID
    logic [4:0]       RsD;
    logic [4:0]       RtD;
    logic             BranchD;
    logic             BranchTakenD;
    // Instruction in EX
    logic [4:0]       RsE;
    logic [4:0]       RtE;
    logic [4:0]       WriteRegE;
    logic             RegWriteE;
    logic             MemReadE;
    logic             MultiE;
    // Instruction in MEM
    logic [4:0]       WriteRegM;
    logic             RegWriteM;
    logic             MemReadM;
    // Instruction in WB
    logic [4:0]       WriteRegW;
    logic             RegWriteW;
    // Controls back to the pipeline
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             FlushD;
    logic             FlushE;
    logic             FlushM;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             MultiBusy;
    logic [CNT_W-1:0] StallCount;

    // Pipeline side: presents stage fields, consumes controls
    modport master (
        output RsD, RtD, BranchD, BranchTakenD,
        output RsE, RtE, WriteRegE, RegWriteE, MemReadE, MultiE,
        output WriteRegM, RegWriteM, MemReadM,
        output WriteRegW, RegWriteW,
        input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
        input  ForwardAE, ForwardBE, MultiBusy, StallCount
    );

    // Controller side
    modport slave (
        input  RsD, RtD, BranchD, BranchTakenD,
        input  RsE, RtE, WriteRegE, RegWriteE, MemReadE, MultiE,
        input  WriteRegM, RegWriteM, MemReadM,
        input  WriteRegW, RegWriteW,
        output StallF, StallD, StallE, FlushD, FlushE, FlushM,
        output ForwardAE, ForwardBE, MultiBusy, StallCount
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: stalls, flushes, ALU forward selects and a saturating stall counter.
// Latency: controls are combinational in the cycle the hazard is visible; counter/FSM update on the next Clk edge.
// Backpressure: multi-cycle EX op freezes F/D/E and bubbles MEM; load-use/branch hazards freeze F/D and bubble EX.
module pipeline_hazard_ctrl #(
    parameter int MULTI_LAT = 4,
    parameter int CNT_W     = 32
) (
    input  logic                  Clk,
    input  logic                  Reset,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic {RUN = 1'b0, MULTI = 1'b1} state_t;

    // A one-cycle op never needs the MULTI state; the countdown covers the cycles after the first
    localparam bit         MULTI_EN = (MULTI_LAT >= 2);
    localparam logic [3:0] CNT_INIT = MULTI_EN ? 4'(MULTI_LAT - 2) : 4'd0;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state, nextState;
    logic [3:0]       cnt, nextCnt;
    logic             multiStall, lwStall, brStall;
    logic             stallF, stallD, stallE, flushD, flushE, flushM, multiBusy;
    logic [1:0]       fwdA, fwdB;
    logic [CNT_W-1:0] stallCnt;

    // Destination matches either source; register 0 is never a real dependency
    function automatic logic regMatch(input logic [4:0] dst, input logic [4:0] a, input logic [4:0] b);
        return (dst != 5'd0) && ((dst == a) || (dst == b));
    endfunction

    // MEM result is newer than WB, so it wins
    function automatic logic [1:0] fwdSel(input logic [4:0] src,
                                          input logic regWrM, input logic [4:0] dstM,
                                          input logic regWrW, input logic [4:0] dstW);
        if (regWrM && (dstM != 5'd0) && (dstM == src))
            return 2'b10;
        else if (regWrW && (dstW != 5'd0) && (dstW == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // FSM state and multi-cycle countdown
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
        end
    end

    // Next state: hold the op in EX until the countdown reaches zero; MultiE ignored while in MULTI
    always_comb begin
        nextState  = state;
        nextCnt    = cnt;
        multiStall = 1'b0;
        case (state)
            RUN: begin
                if (hz.MultiE && MULTI_EN) begin
                    multiStall = 1'b1;
                    nextState  = MULTI;
                    nextCnt    = CNT_INIT;
                end
            end
            MULTI: begin
                if (cnt != 4'd0) begin
                    multiStall = 1'b1;
                    nextCnt    = cnt - 4'd1;
                end else begin
                    nextState = RUN;
                end
            end
        endcase
    end

    // Load-use and branch-compare-in-ID hazards
    always_comb begin
        lwStall = hz.MemReadE && hz.RegWriteE && regMatch(hz.WriteRegE, hz.RsD, hz.RtD);
        brStall = hz.BranchD &&
                  ((hz.RegWriteE && regMatch(hz.WriteRegE, hz.RsD, hz.RtD)) ||
                   (hz.MemReadM  && regMatch(hz.WriteRegM, hz.RsD, hz.RtD)));
    end

    // Stall/flush/forward controls; everything is held low while in reset
    always_comb begin
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        flushM    = 1'b0;
        fwdA      = 2'b00;
        fwdB      = 2'b00;
        multiBusy = 1'b0;
        if (!Reset) begin
            if (multiStall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                flushM = 1'b1;
            end else if (lwStall || brStall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
            flushD    = hz.BranchTakenD && !stallD;
            fwdA      = fwdSel(hz.RsE, hz.RegWriteM, hz.WriteRegM, hz.RegWriteW, hz.WriteRegW);
            fwdB      = fwdSel(hz.RtE, hz.RegWriteM, hz.WriteRegM, hz.RegWriteW, hz.WriteRegW);
            multiBusy = (state == MULTI);
        end
    end

    // Saturating count of cycles spent with the PC held
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            stallCnt <= '0;
        else if (stallF && (stallCnt != CNT_MAX))
            stallCnt <= stallCnt + CNT_W'(1);
    end

    assign hz.StallF     = stallF;
    assign hz.StallD     = stallD;
    assign hz.StallE     = stallE;
    assign hz.FlushD     = flushD;
    assign hz.FlushE     = flushE;
    assign hz.FlushM     = flushM;
    assign hz.ForwardAE  = fwdA;
    assign hz.ForwardBE  = fwdB;
    assign hz.MultiBusy  = multiBusy;
    assign hz.StallCount = stallCnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: combinational vector table plus FSM/reset/saturation sequences.
// Latency: checks controls mid-cycle, counter one edge later.
// Backpressure: n/a (bench drives all inputs).
module tb_pipeline_hazard_ctrl;
    logic Clk = 1'b0;
    logic Reset;
    logic rstSat;

    always #5 Clk = ~Clk;

    pipeline_hazard_ctrl_if #(.CNT_W(32)) hz();
    pipeline_hazard_ctrl_if #(.CNT_W(4))  hzSat();

    pipeline_hazard_ctrl #(.MULTI_LAT(4), .CNT_W(32)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .hz    (hz.slave)
    );

    pipeline_hazard_ctrl #(.MULTI_LAT(4), .CNT_W(4)) dutSat (
        .Clk   (Clk),
        .Reset (rstSat),
        .hz    (hzSat.slave)
    );

    typedef struct {
        logic [4:0] RsD, RtD;
        logic       BranchD, BranchTakenD;
        logic [4:0] RsE, RtE, WriteRegE;
        logic       RegWriteE, MemReadE;
        logic [4:0] WriteRegM;
        logic       RegWriteM, MemReadM;
        logic [4:0] WriteRegW;
        logic       RegWriteW;
        logic       eSF, eSD, eSE, eFD, eFE, eFM;
        logic [1:0] eFA, eFB;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs[NVEC];

    int nCompared = 0;
    int nMismatch = 0;
    int expCnt    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // {StallF,StallD,StallE,FlushD,FlushE,FlushM,ForwardAE,ForwardBE}
    function automatic logic [9:0] ctrlNow();
        return {hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE, hz.FlushM,
                hz.ForwardAE, hz.ForwardBE};
    endfunction

    function automatic logic [9:0] ctrlExp(input logic sf, input logic sd, input logic se,
                                           input logic fd, input logic fe, input logic fm,
                                           input logic [1:0] fa, input logic [1:0] fb);
        return {sf, sd, se, fd, fe, fm, fa, fb};
    endfunction

    task automatic clearIn();
        hz.RsD = 5'd0; hz.RtD = 5'd0; hz.BranchD = 1'b0; hz.BranchTakenD = 1'b0;
        hz.RsE = 5'd0; hz.RtE = 5'd0; hz.WriteRegE = 5'd0;
        hz.RegWriteE = 1'b0; hz.MemReadE = 1'b0; hz.MultiE = 1'b0;
        hz.WriteRegM = 5'd0; hz.RegWriteM = 1'b0; hz.MemReadM = 1'b0;
        hz.WriteRegW = 5'd0; hz.RegWriteW = 1'b0;
    endtask

    task automatic applyVec(input vec_t v);
        hz.RsD = v.RsD; hz.RtD = v.RtD; hz.BranchD = v.BranchD; hz.BranchTakenD = v.BranchTakenD;
        hz.RsE = v.RsE; hz.RtE = v.RtE; hz.WriteRegE = v.WriteRegE;
        hz.RegWriteE = v.RegWriteE; hz.MemReadE = v.MemReadE; hz.MultiE = 1'b0;
        hz.WriteRegM = v.WriteRegM; hz.RegWriteM = v.RegWriteM; hz.MemReadM = v.MemReadM;
        hz.WriteRegW = v.WriteRegW; hz.RegWriteW = v.RegWriteW;
    endtask

    task automatic setLoadUse();
        hz.MemReadE = 1'b1; hz.RegWriteE = 1'b1; hz.WriteRegE = 5'd8; hz.RsD = 5'd8;
    endtask

    task automatic stepCycle();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        // Vector table: single-cycle hazard and forwarding cases, MultiE low
        vecs[0]  = '{default: '0};
        vecs[1]  = '{MemReadE: 1'b1, RegWriteE: 1'b1, WriteRegE: 5'd8, RsD: 5'd8,
                     eSF: 1'b1, eSD: 1'b1, eFE: 1'b1, default: '0};
        vecs[2]  = '{MemReadE: 1'b1, RegWriteE: 1'b1, WriteRegE: 5'd8, RsD: 5'd2, RtD: 5'd8,
                     eSF: 1'b1, eSD: 1'b1, eFE: 1'b1, default: '0};
        vecs[3]  = '{MemReadE: 1'b1, RegWriteE: 1'b1, WriteRegE: 5'd0, RsD: 5'd0, default: '0};
        vecs[4]  = '{MemReadE: 1'b1, RegWriteE: 1'b0, WriteRegE: 5'd8, RsD: 5'd8, default: '0};
        vecs[5]  = '{MemReadE: 1'b1, RegWriteE: 1'b1, WriteRegE: 5'd8, RsD: 5'd9, RtD: 5'd10,
                     default: '0};
        vecs[6]  = '{BranchD: 1'b1, BranchTakenD: 1'b1, RtD: 5'd5, RegWriteE: 1'b1, WriteRegE: 5'd5,
                     eSF: 1'b1, eSD: 1'b1, eFE: 1'b1, default: '0};
        vecs[7]  = '{BranchD: 1'b1, BranchTakenD: 1'b1, RsD: 5'd1, RtD: 5'd2, eFD: 1'b1,
                     default: '0};
        vecs[8]  = '{BranchD: 1'b1, RsD: 5'd7, MemReadM: 1'b1, WriteRegM: 5'd7,
                     eSF: 1'b1, eSD: 1'b1, eFE: 1'b1, default: '0};
        vecs[9]  = '{RegWriteE: 1'b1, WriteRegE: 5'd5, RtD: 5'd5, default: '0};
        vecs[10] = '{RsE: 5'd3, RegWriteM: 1'b1, WriteRegM: 5'd3, RegWriteW: 1'b1, WriteRegW: 5'd3,
                     eFA: 2'b10, default: '0};
        vecs[11] = '{RsE: 5'd3, RegWriteM: 1'b0, WriteRegM: 5'd3, RegWriteW: 1'b1, WriteRegW: 5'd3,
                     eFA: 2'b01, default: '0};
        vecs[12] = '{RtE: 5'd0, RegWriteM: 1'b1, WriteRegM: 5'd0, RegWriteW: 1'b1, WriteRegW: 5'd0,
                     default: '0};
        vecs[13] = '{RsE: 5'd4, RtE: 5'd4, RegWriteM: 1'b1, WriteRegM: 5'd4,
                     eFA: 2'b10, eFB: 2'b10, default: '0};
        vecs[14] = '{RtE: 5'd6, RegWriteW: 1'b1, WriteRegW: 5'd6, RegWriteM: 1'b1, WriteRegM: 5'd7,
                     eFB: 2'b01, default: '0};
        vecs[15] = '{BranchD: 1'b1, MemReadM: 1'b1, WriteRegM: 5'd0, RsD: 5'd0, default: '0};

        // Saturation instance: a permanent load-use hazard, held in reset until its test
        rstSat = 1'b1;
        hzSat.RsD = 5'd8; hzSat.RtD = 5'd0; hzSat.BranchD = 1'b0; hzSat.BranchTakenD = 1'b0;
        hzSat.RsE = 5'd0; hzSat.RtE = 5'd0; hzSat.WriteRegE = 5'd8;
        hzSat.RegWriteE = 1'b1; hzSat.MemReadE = 1'b1; hzSat.MultiE = 1'b0;
        hzSat.WriteRegM = 5'd0; hzSat.RegWriteM = 1'b0; hzSat.MemReadM = 1'b0;
        hzSat.WriteRegW = 5'd0; hzSat.RegWriteW = 1'b0;

        // Reset forces every control low even with hazards on the inputs
        Reset = 1'b1;
        clearIn();
        setLoadUse();
        hz.MultiE = 1'b1; hz.BranchTakenD = 1'b1;
        hz.RsE = 5'd3; hz.RegWriteM = 1'b1; hz.WriteRegM = 5'd3;
        #3;
        check("reset_ctrl", 32'(ctrlNow()), 32'd0);
        check("reset_busy", 32'(hz.MultiBusy), 32'd0);
        @(posedge Clk); #1;
        check("reset_count", hz.StallCount, 32'd0);
        check("reset_busy_after_edge", 32'(hz.MultiBusy), 32'd0);
        clearIn();
        Reset = 1'b0;
        stepCycle();

        // Table-driven combinational vectors
        for (int i = 0; i < NVEC; i++) begin
            applyVec(vecs[i]);
            #3;
            check($sformatf("vec%0d_ctrl", i), 32'(ctrlNow()),
                  32'(ctrlExp(vecs[i].eSF, vecs[i].eSD, vecs[i].eSE, vecs[i].eFD,
                              vecs[i].eFE, vecs[i].eFM, vecs[i].eFA, vecs[i].eFB)));
            if (vecs[i].eSF) expCnt++;
            stepCycle();
        end
        clearIn();
        #1;
        check("count_after_vectors", hz.StallCount, 32'(expCnt));

        // Two back-to-back multi-cycle ops, with a load-use hazard and a taken branch
        // during the stall cycles (both must be ignored, FlushD held low)
        hz.MultiE = 1'b1;
        for (int k = 0; k < 9; k++) begin
            int ph;
            ph = k % 4;
            clearIn();
            hz.MultiE = (k < 8);
            if (ph == 1 || ph == 2) begin
                setLoadUse();
                hz.BranchTakenD = 1'b1;
            end
            #3;
            if (k < 8 && ph < 3) begin
                check($sformatf("multi_c%0d_ctrl", k), 32'(ctrlNow()),
                      32'(ctrlExp(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00)));
                expCnt++;
            end else begin
                check($sformatf("multi_c%0d_ctrl", k), 32'(ctrlNow()), 32'd0);
            end
            check($sformatf("multi_c%0d_busy", k), 32'(hz.MultiBusy),
                  32'((k < 8) && (ph >= 1)));
            stepCycle();
        end
        clearIn();
        #1;
        check("count_after_multi", hz.StallCount, 32'(expCnt));

        // Asynchronous reset in MULTI with cnt=1, then a fresh op
        stepCycle();
        hz.MultiE = 1'b1;
        stepCycle();
        stepCycle();
        #2;
        check("pre_reset_multi_ctrl", 32'(ctrlNow()),
              32'(ctrlExp(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00)));
        check("pre_reset_multi_busy", 32'(hz.MultiBusy), 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        check("async_reset_ctrl", 32'(ctrlNow()), 32'd0);
        check("async_reset_busy", 32'(hz.MultiBusy), 32'd0);
        check("async_reset_count", hz.StallCount, 32'd0);
        expCnt = 0;
        stepCycle();
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #3;
            if (k < 3) begin
                check($sformatf("fresh_c%0d_ctrl", k), 32'(ctrlNow()),
                      32'(ctrlExp(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00)));
                expCnt++;
            end else begin
                check($sformatf("fresh_c%0d_ctrl", k), 32'(ctrlNow()), 32'd0);
            end
            check($sformatf("fresh_c%0d_busy", k), 32'(hz.MultiBusy), 32'(k >= 1));
            stepCycle();
        end
        hz.MultiE = 1'b0;
        #1;
        check("count_after_fresh", hz.StallCount, 32'(expCnt));
        check("idle_busy", 32'(hz.MultiBusy), 32'd0);

        // 4-bit counter saturation under a permanent stall
        check("sat_reset_count", 32'(hzSat.StallCount), 32'd0);
        rstSat = 1'b0;
        repeat (10) stepCycle();
        check("sat_count_10", 32'(hzSat.StallCount), 32'd10);
        check("sat_stallf", 32'(hzSat.StallF), 32'd1);
        repeat (10) stepCycle();
        check("sat_count_20", 32'(hzSat.StallCount), 32'd15);
        repeat (3) stepCycle();
        check("sat_count_hold", 32'(hzSat.StallCount), 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end
endmodule
